pixel_stream_tx: RTL and testbench
==================================

// Module: pixel_stream_tx
// PURPOSE
// - Frame transmitter feeding the pixel-processing chain (edge filter et al.) in raster order.
// - Reads a synchronous frame RAM with 1-cycle read latency.
// - Emits one 24-bit pixel per valid/ready handshake, with start-of-frame and end-of-line markers.
// - Started per frame by a one-cycle start pulse; signals completion with done.
// PARAMETERS
// - WIDTH   640  pixels per line
// - HEIGHT  480  lines per frame
// - PIX_W   24   pixel width (RGB 8:8:8, R in [23:16])
// - ADDR_W  $clog2(WIDTH*HEIGHT)  frame RAM address width
// PORTS
// - clk        in   1       single clock; all logic on posedge
// - rst        in   1       asynchronous, active-low reset
// - start      in   1       one-cycle pulse; begins a frame when idle
// - busy       out  1       high from accepted start until done
// - done       out  1       one-cycle pulse after the last pixel handshake
// - mem_rd     out  1       RAM read strobe
// - mem_addr   out  ADDR_W  RAM read address = y*WIDTH + x
// - mem_data   in   PIX_W   RAM data; valid the cycle after mem_rd
// - pix_out    out  PIX_W   output pixel
// - pix_valid  out  1       pix_out/pix_sof/pix_eol valid
// - pix_ready  in   1       downstream accepts when pix_valid & pix_ready
// - pix_sof    out  1       first pixel of frame (x=0, y=0)
// - pix_eol    out  1       last pixel of a line (x=WIDTH-1)
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, counters 0, buffer empty. Reset mid-frame aborts the frame; no done pulse.
// - FSM states:
//   - IDLE: start -> RUN.
//   - RUN: after the last read is issued -> DRAIN.
//   - DRAIN: buffer empty and nothing in flight -> IDLE, with done=1 for that cycle.
// - start is ignored while busy.
// - Read issue rule: mem_rd=1 in RUN iff occupancy + inflight - pop < 2, where:
//   - occupancy: entries held in the 2-entry output buffer
//   - inflight: a read issued last cycle
//   - pop: pix_valid & pix_ready this cycle
// - The buffer can never overflow. Full throughput (1 pixel/clk) is sustained while pix_ready=1.
// - Counters: x wraps WIDTH-1 -> 0 and increments y. The last read is at x=WIDTH-1, y=HEIGHT-1.
// - mem_addr is a running counter, not a multiplier.
// - pix_sof and pix_eol are captured at read issue and travel with the data through the buffer.
// - Latency: start in cycle 0 -> mem_rd=1, addr=0 in cycle 1 -> pix_valid=1 in cycle 2 if pix_ready was high.
// - Stall rule: pix_out, pix_sof, pix_eol stay stable while pix_valid & ~pix_ready. pix_valid never drops without a handshake.
// - Simultaneous push and pop when full: the pop completes and the push lands, so occupancy stays 2 (the issue rule guarantees this).
// - busy=1 from the cycle after the accepted start through the done cycle inclusive.
// CONFIGURATION
// - Macro: PIX_TX_TEST_PATTERN_EN
// - Defined:
//   - mem_rd held 0; mem_data ignored.
//   - Pixel = {x[7:0], y[7:0], 8'h00}, generated through a register.
//   - Latency, handshake and markers are identical to RAM mode.
// - Undefined: pixels come from mem_data.
// STRUCTURE
// - Package pix_stream_pkg:
//   - typedef pixel_t (logic [23:0])
//   - typedef struct pix_beat_t {pixel_t pix; logic sof, eol;}
//   - enum tx_state_t {IDLE, RUN, DRAIN}
// - Sub-module pix_skid_buf: 2-entry FIFO of pix_beat_t.
//   - Ports: push, beat_in, pop, beat_out, count[1:0].
//   - Async active-low reset.
// TESTING (bench: WIDTH=4, HEIGHT=3, RAM[a]=a)
// - Reset, start, pix_ready=1:
//   - 12 beats of pix_out=0..11 on consecutive cycles, first beat in cycle 2.
//   - pix_sof on beat 0 only; pix_eol on beats 3, 7 and 11.
//   - done one cycle after beat 11; busy low the cycle after done.
// - pix_ready=0 for 5 cycles from beat 2:
//   - pix_out holds 2; mem_rd deasserts once 2 are buffered.
//   - Stream resumes with 3, 4, ... and no beat is lost or duplicated.
// - Random pix_ready at 30%: the received sequence is exactly 0..11 with correct markers.
// - start pulsed mid-frame: ignored, the stream is unchanged, a single done.
// - rst low at beat 5:
//   - All outputs 0 immediately; no done.
//   - The next start restarts from pixel 0 with pix_sof.
// - PIX_TX_TEST_PATTERN_EN defined: beat 5 (x=1, y=1) = 24'h010100; mem_rd never asserts.

Source files
------------

// File: rtl/pix_stream_pkg.sv
// pix_stream_pkg
// Shared types for the pixel stream transmitter:
//   pixel_t    - 24-bit RGB 8:8:8 pixel, R in [23:16]
//   pix_beat_t - one output beat: pixel plus start-of-frame / end-of-line markers
//   tx_state_t - transmitter FSM states
package pix_stream_pkg;

    typedef logic [23:0] pixel_t;

    typedef struct packed {
        pixel_t pix;
        logic   sof;
        logic   eol;
    } pix_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } tx_state_t;

endpackage

// File: rtl/pix_skid_buf.sv
// pix_skid_buf
// Two-entry fall-through FIFO of pix_beat_t sitting between the frame RAM
// read port and the valid/ready output.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   push       beat_in is written this cycle
//   beat_in    incoming beat
//   pop        head beat is consumed this cycle
//   beat_out   head beat (beat_in itself while empty)
//   count      entries held (0..2)
module pix_skid_buf
    import pix_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  pix_beat_t  beat_in,
    input  logic       pop,
    output pix_beat_t  beat_out,
    output logic [1:0] count
);

    pix_beat_t store_mem [2];
    logic      rd_ptr;
    logic      wr_ptr;
    logic      store;
    logic      deq;

    // While empty, an incoming beat popped in the same cycle passes straight
    // through and is never stored.
    assign store    = push && !((count == 2'd0) && pop);
    assign deq      = pop && (count != 2'd0);
    assign beat_out = (count == 2'd0) ? beat_in : store_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (store) begin
            store_mem[wr_ptr] <= beat_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) begin
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(store) - 2'(deq);
        end
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx
// Streams one frame in raster order from a synchronous frame RAM (1-cycle
// read latency) as valid/ready beats with start-of-frame and end-of-line
// markers. One start pulse per frame; done pulses after the last handshake.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start                     one-cycle frame request (ignored while busy)
//   busy, done                frame in progress / one-cycle completion pulse
//   mem_rd, mem_addr          RAM read strobe and address (y*WIDTH + x)
//   mem_data                  RAM read data, valid the cycle after mem_rd
//   pix_out, pix_valid        output beat and its valid
//   pix_ready                 downstream accept
//   pix_sof, pix_eol          first pixel of frame / last pixel of line
// Configuration macro PIX_TX_TEST_PATTERN_EN: when defined, the RAM is not
// read and each pixel is {x[7:0], y[7:0], 8'h00}, with identical timing.
module pixel_stream_tx
    import pix_stream_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int PIX_W  = 24,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    tx_state_t     state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          inflight;
    logic          sof_q;
    logic          eol_q;
    logic [1:0]    count;
    logic          pop;
    logic          rd_issue;
    logic          last_rd;
    logic [2:0]    remaining;
    pix_beat_t     beat_in;
    pix_beat_t     beat_out;

    // Beats still owed downstream after this cycle's pop; reads are issued
    // only while that stays below the buffer depth, so it never overflows.
    assign pix_valid = (count != 2'd0) || inflight;
    assign pop       = pix_valid && pix_ready;
    assign remaining = 3'(count) + 3'(inflight) - 3'(pop);
    assign rd_issue  = (state == RUN) && (remaining < 3'd2);
    assign last_rd   = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));

`ifdef PIX_TX_TEST_PATTERN_EN
    pixel_t pat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= '0;
        end else if (rd_issue) begin
            pat_q <= {8'(x), 8'(y), 8'h00};
        end
    end

    assign mem_rd = 1'b0;

    always_comb begin
        beat_in     = '0;
        beat_in.pix = pat_q;
        beat_in.sof = sof_q;
        beat_in.eol = eol_q;
    end
`else
    assign mem_rd = rd_issue;

    always_comb begin
        beat_in     = '0;
        beat_in.pix = pixel_t'(mem_data);
        beat_in.sof = sof_q;
        beat_in.eol = eol_q;
    end
`endif

    pix_skid_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .beat_in  (beat_in),
        .pop      (pop),
        .beat_out (beat_out),
        .count    (count)
    );

    assign pix_out = pix_valid ? PIX_W'(beat_out.pix) : '0;
    assign pix_sof = pix_valid && beat_out.sof;
    assign pix_eol = pix_valid && beat_out.eol;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            inflight <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            x        <= '0;
            y        <= '0;
            mem_addr <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= rd_issue;

            // Markers are captured with the read so they arrive alongside its data.
            if (rd_issue) begin
                sof_q    <= (x == '0) && (y == '0);
                eol_q    <= (x == XW'(WIDTH - 1));
                mem_addr <= mem_addr + ADDR_W'(1);
                if (x == XW'(WIDTH - 1)) begin
                    x <= '0;
                    y <= (y == YW'(HEIGHT - 1)) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end

            case (state)
                IDLE: begin
                    // busy stays high through the done cycle, which masks start.
                    if (done) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        x        <= '0;
                        y        <= '0;
                        mem_addr <= '0;
                    end
                end
                RUN: begin
                    if (rd_issue && last_rd) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (remaining == 3'd0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx
// Scoreboard bench for pixel_stream_tx with WIDTH=4, HEIGHT=3 and a RAM
// model holding RAM[a] = a. Expected beats are queued when a frame is
// started; a negedge monitor pops and compares on every handshake.
module tb_pixel_stream_tx;
    import pix_stream_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = $clog2(W * H);

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          start     = 1'b0;
    logic          pix_ready = 1'b0;
    logic [23:0]   mem_data  = '0;
    logic          busy;
    logic          done;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [23:0]   pix_out;
    logic          pix_valid;
    logic          pix_sof;
    logic          pix_eol;

    int tests   = 0;
    int fails   = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int rd_cnt  = 0;

    pix_beat_t   exp_q [$];
    int          beat_cyc [$];
    logic        held_v = 1'b0;
    logic [25:0] held   = '0;

    pixel_stream_tx #(
        .WIDTH  (W),
        .HEIGHT (H),
        .PIX_W  (24),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame RAM: RAM[a] = a, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= 24'(mem_addr);
    end

    function automatic pixel_t exp_pix(input int i);
        logic [7:0] xb;
        logic [7:0] yb;
        xb = 8'(i % W);
        yb = 8'(i / W);
`ifdef PIX_TX_TEST_PATTERN_EN
        return {xb, yb, 8'h00};
`else
        return 24'(i) | 24'({xb, yb} & 16'h0);
`endif
    endfunction

    function automatic pix_beat_t exp_beat(input int i);
        pix_beat_t b;
        b.pix = exp_pix(i);
        b.sof = (i == 0);
        b.eol = ((i % W) == (W - 1));
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: handshakes are compared against the scoreboard; stalls must hold the beat.
    always @(negedge clk) begin
        pix_beat_t e;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (mem_rd) rd_cnt = rd_cnt + 1;
        if (pix_valid && pix_ready) begin
            beat_cyc.push_back(cyc);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected: got pix=0x%06h sof=%0b eol=%0b, expected no beat (cycle %0d)",
                         pix_out, pix_sof, pix_eol, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({pix_out, pix_sof, pix_eol} !== {e.pix, e.sof, e.eol}) begin
                    fails++;
                    $display("FAIL beat: got pix=0x%06h sof=%0b eol=%0b, expected pix=0x%06h sof=%0b eol=%0b (cycle %0d)",
                             pix_out, pix_sof, pix_eol, e.pix, e.sof, e.eol, cyc);
                end
            end
            held_v = 1'b0;
        end else if (pix_valid) begin
            if (held_v) check("stall_stable", 32'({pix_out, pix_sof, pix_eol}), 32'(held));
            held_v = 1'b1;
            held   = {pix_out, pix_sof, pix_eol};
        end else begin
            if (held_v && rst) check("valid_dropped", 32'(pix_valid), 32'd1);
            held_v = 1'b0;
        end
    end

    task automatic push_frame();
        for (int i = 0; i < N; i++) exp_q.push_back(exp_beat(i));
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk);
        #1 start = 1'b1;
        s = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        int n;
        n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_mem_rd"},    32'(mem_rd),    32'd0);
        check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_pix_out"},   32'(pix_out),   32'd0);
        check({tag, "_pix_sof"},   32'(pix_sof),   32'd0);
        check({tag, "_pix_eol"},   32'(pix_eol),   32'd0);
    endtask

    initial begin
        int s;
        int d0;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Full-rate frame with exact timing.
        pix_ready = 1'b1;
        beat_cyc.delete();
        d0 = done_cnt;
        push_frame();
        pulse_start(s);
        @(negedge clk);
        check("t1_busy_s1", 32'(busy), 32'd1);
`ifdef PIX_TX_TEST_PATTERN_EN
        check("t1_mem_rd_s1", 32'(mem_rd), 32'd0);
`else
        check("t1_mem_rd_s1", 32'(mem_rd), 32'd1);
`endif
        check("t1_mem_addr_s1", 32'(mem_addr), 32'd0);
        wait_done(d0, 100);
        check("t1_beats", 32'(beat_cyc.size()), 32'(N));
        check("t1_first_beat_cyc", 32'((beat_cyc.size() > 0) ? beat_cyc[0] : -1), 32'(s + 2));
        check("t1_last_beat_cyc", 32'((beat_cyc.size() > N - 1) ? beat_cyc[N-1] : -1), 32'(s + 13));
        check("t1_done_cyc", 32'(done_cyc), 32'(s + 14));
        @(negedge clk);
        check("t1_busy_after_done", 32'(busy), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: pix_ready low for 5 cycles starting at beat 2.
        beat_cyc.delete();
        d0 = done_cnt;
        push_frame();
        pulse_start(s);
        repeat (3) @(posedge clk);
        #1 pix_ready = 1'b0;
        @(negedge clk);
        check("t2_hold_pix_s4", 32'(pix_out), 32'(exp_pix(2)));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t2_mem_rd_off", 32'(mem_rd), 32'd0);
        check("t2_hold_pix_s6", 32'(pix_out), 32'(exp_pix(2)));
        check("t2_valid_held", 32'(pix_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 pix_ready = 1'b1;
        wait_done(d0, 100);
        check("t2_beats", 32'(beat_cyc.size()), 32'(N));
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Random pix_ready, high 30% of cycles.
        beat_cyc.delete();
        d0 = done_cnt;
        push_frame();
        pulse_start(s);
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(posedge clk);
            #1 pix_ready = ($urandom_range(0, 99) < 30);
            n++;
        end
        check("t3_done_seen", 32'(done_cnt - d0), 32'd1);
        check("t3_beats", 32'(beat_cyc.size()), 32'(N));
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        pix_ready = 1'b1;
        repeat (2) @(posedge clk);

        // start pulsed mid-frame must be ignored.
        beat_cyc.delete();
        d0 = done_cnt;
        push_frame();
        pulse_start(s);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(d0, 100);
        repeat (20) @(posedge clk);
        check("t4_single_done", 32'(done_cnt - d0), 32'd1);
        check("t4_beats", 32'(beat_cyc.size()), 32'(N));
        check("t4_busy_idle", 32'(busy), 32'd0);

        // Reset asserted while beat 5 is presented aborts the frame.
        beat_cyc.delete();
        d0 = done_cnt;
        push_frame();
        pulse_start(s);
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_idle_outputs("t5_rst");
        check("t5_beats_before_rst", 32'(beat_cyc.size()), 32'd5);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);

        // Restart after reset begins again at pixel 0 with sof.
        beat_cyc.delete();
        d0 = done_cnt;
        push_frame();
        pulse_start(s);
        wait_done(d0, 100);
        check("t6_beats", 32'(beat_cyc.size()), 32'(N));
        check("t6_first_beat_cyc", 32'((beat_cyc.size() > 0) ? beat_cyc[0] : -1), 32'(s + 2));

`ifdef PIX_TX_TEST_PATTERN_EN
        check("pattern_mem_rd_never", 32'(rd_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
